// File: rtl/apu_frame_counter_if.sv
// apu_frame_counter_if: $4017/$4015 side of the frame sequencer.
// master drives wr/wdata/status_rd; slave drives qframe/hframe/irq/mode.
interface apu_frame_counter_if;
  logic       wr;
  logic [7:0] wdata;
  logic       status_rd;
  logic       qframe;
  logic       hframe;
  logic       irq;
  logic       mode;

  modport master (
    output wr, wdata, status_rd,
    input  qframe, hframe, irq, mode
  );

  modport slave (
    input  wr, wdata, status_rd,
    output qframe, hframe, irq, mode
  );
endinterface

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: APU frame sequencer, quarter/half-frame strobes.
// Ports: clk, n_reset, bus (wr, wdata, status_rd in; qframe, hframe, irq,
// mode out). APU_FRAME_IRQ_EN adds frame IRQ + inhibit; else irq is 0.
module apu_frame_counter #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281,
  parameter int CW    = 16
) (
  input logic clk,
  input logic n_reset,
  apu_frame_counter_if.slave bus
);

  localparam logic [CW-1:0] S1  = CW'(STEP1);
  localparam logic [CW-1:0] S2  = CW'(STEP2);
  localparam logic [CW-1:0] S3  = CW'(STEP3);
  localparam logic [CW-1:0] S4  = CW'(STEP4);
  localparam logic [CW-1:0] S4M = CW'(STEP4 - 1);
  localparam logic [CW-1:0] S4P = CW'(STEP4 + 1);
  localparam logic [CW-1:0] S5  = CW'(STEP5);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [2:0]    dly;
  logic          phase;
  logic          mode_q;
  logic          pend;
  logic          qf;
  logic          hf;
  logic          end_hit;
  logic          q_hit;
  logic          h_hit;
  logic          expire;

  // 4-step runs one count past STEP4 to close the IRQ window.
  assign last    = mode_q ? S5 : S4P;
  assign end_hit = mode_q ? (cnt == S5) : (cnt == S4);
  assign h_hit   = (cnt == S2) | end_hit;
  assign q_hit   = (cnt == S1) | (cnt == S3) | h_hit;

  // A new write in the expiry cycle restarts the delay instead.
  assign expire  = (dly == 3'd1) & ~bus.wr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt    <= '0;
      dly    <= 3'd0;
      phase  <= 1'b0;
      mode_q <= 1'b0;
      pend   <= 1'b0;
      qf     <= 1'b0;
      hf     <= 1'b0;
    end else begin
      phase <= ~phase;
      if (bus.wr) begin
        dly  <= phase ? 3'd3 : 3'd4;
        pend <= bus.wdata[7];
      end else if (dly != 3'd0) begin
        dly <= dly - 3'd1;
      end
      if (expire) begin
        cnt    <= '0;
        mode_q <= pend;
        qf     <= pend;
        hf     <= pend;
      end else begin
        cnt <= (cnt == last) ? '0 : cnt + 1'b1;
        qf  <= q_hit;
        hf  <= h_hit;
      end
    end
  end

  assign bus.qframe = qf;
  assign bus.hframe = hf;
  assign bus.mode   = mode_q;

`ifdef APU_FRAME_IRQ_EN
  logic inhibit;
  logic irq_q;
  logic irq_set;
  logic irq_wclr;
  logic unused_bits;

  assign irq_set  = ~mode_q & ~inhibit &
                    ((cnt == S4M) | (cnt == S4) | (cnt == S4P));
  assign irq_wclr = bus.wr & bus.wdata[6];

  // inhibit write beats a set; a set beats a status read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      inhibit <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (bus.wr)
        inhibit <= bus.wdata[6];
      unique case (1'b1)
        irq_wclr:      irq_q <= 1'b0;
        irq_set:       irq_q <= 1'b1;
        bus.status_rd: irq_q <= 1'b0;
        default:       irq_q <= irq_q;
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign unused_bits = ^bus.wdata[5:0];
`else
  logic unused_bits;

  assign bus.irq     = 1'b0;
  assign unused_bits = ^{bus.status_rd, bus.wdata[6:0]};
`endif

endmodule

// File: tb/tb_apu_frame_counter.sv
// tb_apu_frame_counter: scoreboard bench for apu_frame_counter.
// Scaled step constants keep the run short; ratios match the real table.
module tb_apu_frame_counter;

  localparam int S1 = 75;
  localparam int S2 = 149;
  localparam int S3 = 224;
  localparam int S4 = 298;
  localparam int S5 = 373;
  localparam int CW = 9;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  logic clk;
  logic n_reset;
  apu_frame_counter_if bus ();

  apu_frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3),
    .STEP4(S4), .STEP5(S5), .CW(CW)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nq, nh, ni, fq, w0;

  // reference: sequence start cycle, mode and a scheduled restart
  int m_start, m_pat;
  bit m_mode, m_pv, m_pm, m_inh, m_irq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_start = 0; m_pat = 0;
    m_mode = 0; m_pv = 0; m_pm = 0;
    m_inh = 0; m_irq = 0;
  endtask

  task automatic clr_cnt();
    nq = 0; nh = 0; ni = 0; fq = -1;
  endtask

  task automatic model_step(input logic w,
                            input logic [7:0] d,
                            input logic rd);
    int per, pos, last;
    bit ex, q, h;
    per  = m_mode ? S5 + 1 : S4 + 2;
    pos  = (cyc - m_start) % per;
    last = m_mode ? S5 : S4;
    ex   = m_pv && (m_pat == cyc + 1) && !w;
    if (ex) begin
      q = m_pm;
      h = m_pm;
    end else begin
      h = (pos == S2) || (pos == last);
      q = h || (pos == S1) || (pos == S3);
    end
`ifdef APU_FRAME_IRQ_EN
    begin
      bit set;
      set = !m_mode && !m_inh &&
            pos >= S4 - 1 && pos <= S4 + 1;
      if (w && d[6]) m_irq = 0;
      else if (set)  m_irq = 1;
      else if (rd)   m_irq = 0;
      if (w) m_inh = d[6];
    end
`endif
    if (ex) begin
      m_start = cyc + 1;
      m_mode  = m_pm;
      m_pv    = 0;
    end
    if (w) begin
      m_pv  = 1;
      m_pm  = d[7];
      m_pat = cyc + 1 + ((cyc % 2 == 1) ? 3 : 4);
    end
    sbq.push_back('{cyc + 1, {q, h, m_irq, m_mode}});
  endtask

  // called at a negedge; cycle cyc is the one being driven
  task automatic tick(input logic w,
                      input logic [7:0] d,
                      input logic rd);
    exp_t e;
    bus.wr = w;
    bus.wdata = d;
    bus.status_rd = rd;
    model_step(w, d, rd);
    @(posedge clk);
    cyc++;
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("out@%0d", e.cyc),
          {bus.qframe, bus.hframe, bus.irq, bus.mode}, e.v);
    end
    nq += int'(bus.qframe);
    nh += int'(bus.hframe);
    ni += int'(bus.irq);
    if (bus.qframe && fq < 0) fq = cyc;
    @(negedge clk);
    bus.wr = 1'b0;
    bus.status_rd = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    n_reset = 1'b0;
    bus.wr = 1'b0;
    bus.wdata = 8'h00;
    bus.status_rd = 1'b0;
    m_reset();
    clr_cnt();
    repeat (3) @(negedge clk);
    chk("rst_q", bus.qframe, 0);
    chk("rst_h", bus.hframe, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_mode", bus.mode, 0);

    n_reset = 1'b1;
    cyc = 0;

    // free-running 4-step, status read inside the set window
    run(298);
    tick(1'b0, 8'h00, 1'b1);
    chk("irq_set_wins", bus.irq, IRQ_ON);
    run(6);
    chk("irq_held", bus.irq, IRQ_ON);
    tick(1'b0, 8'h00, 1'b1);
    chk("irq_rd_clr", bus.irq, 0);
    chk("q4_count", nq, 4);
    chk("h4_count", nh, 2);
    clr_cnt();
    run(94);
    chk("q_after_wrap", fq, 376);

    // inhibit write while irq is high, coinciding with a set
    run(199);
    chk("irq_win2", bus.irq, IRQ_ON);
    tick(1'b1, 8'h40, 1'b0);
    chk("irq_inh_clr", bus.irq, 0);
    clr_cnt();
    run(1000);
    chk("irq_inh_none", ni, 0);

    // 5-step write on odd phase: 3-cycle delay, immediate strobes
    if (cyc % 2 == 0) run(1);
    clr_cnt();
    w0 = cyc;
    tick(1'b1, 8'h80, 1'b0);
    run(3);
    chk("imm_qh_dly3", {bus.qframe, bus.hframe}, 2'b11);
    chk("imm_dly3_at", fq, w0 + 4);
    chk("mode5", bus.mode, 1);
    clr_cnt();
    run(S5 + 1);
    chk("q5_count", nq, 4);
    chk("h5_count", nh, 2);
    chk("irq5_none", ni, 0);

    // 5-step write on even phase: 4-cycle delay
    if (cyc % 2 == 1) run(1);
    clr_cnt();
    w0 = cyc;
    tick(1'b1, 8'h80, 1'b0);
    run(4);
    chk("imm_qh_dly4", {bus.qframe, bus.hframe}, 2'b11);
    chk("imm_dly4_at", fq, w0 + 5);

    // back to 4-step, then a write overridden one cycle later
    if (cyc % 2 == 0) run(1);
    tick(1'b1, 8'h00, 1'b0);
    run(3);
    chk("mode4", bus.mode, 0);
    chk("mode4_no_imm", bus.qframe, 0);
    if (cyc % 2 == 0) run(1);
    clr_cnt();
    w0 = cyc;
    tick(1'b1, 8'h80, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    run(20);
    chk("ovr_no_q", nq, 0);
    chk("ovr_no_h", nh, 0);
    chk("ovr_mode", bus.mode, 0);
    run(70);
    chk("ovr_restart", fq, w0 + 1 + 5 + S1 + 1);

    // reset while a 5-step write is pending
    tick(1'b1, 8'h80, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    n_reset = 1'b0;
    #1;
    chk("rst2_out",
        {bus.qframe, bus.hframe, bus.irq, bus.mode}, 0);
    sbq.delete();
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst2_hold",
        {bus.qframe, bus.hframe, bus.irq, bus.mode}, 0);
    n_reset = 1'b1;
    cyc = 0;
    clr_cnt();
    run(310);
    chk("post_q", nq, 4);
    chk("post_h", nh, 2);
    chk("post_irq", ni, IRQ_ON ? 13 : 0);
    chk("post_mode", bus.mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
